// File: rtl/dl_shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with one elastic slot per stage.
// Shift levels are spread across NUM_STAGES registers; valid/ready on both sides.
module dl_shift_pipe #(
  parameter int unsigned NUM_BITS   = 32,
  parameter int unsigned NUM_STAGES = 2,
  localparam int unsigned NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_op,
  input  logic [NUM_BITS-1:0]       in_data,
  input  logic [NUM_SHIFT_BITS-1:0] in_shamt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_BITS-1:0]       out_data
);

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2,
    OP_ROL = 2'd3
  } op_e;

  localparam logic [NUM_BITS-1:0] ALL_ONES = '1;

  // One decomposition level: shift/rotate by a power of two.
  function automatic logic [NUM_BITS-1:0] f_level(
    input logic [1:0]          op,
    input logic [NUM_BITS-1:0] d,
    input logic                sign,
    input int unsigned         amt
  );
    logic [NUM_BITS-1:0] fill;
    fill = sign ? ~(ALL_ONES >> amt) : '0;
    case (op_e'(op))
      OP_SLL:  f_level = d << amt;
      OP_SRL:  f_level = d >> amt;
      OP_SRA:  f_level = (d >> amt) | fill;
      default: f_level = (d << amt) | (d >> (NUM_BITS - amt));
    endcase
  endfunction

  logic                      w_valid [NUM_STAGES];
  logic [NUM_BITS-1:0]       w_data  [NUM_STAGES];
  logic [1:0]                w_op    [NUM_STAGES];
  logic [NUM_SHIFT_BITS-1:0] w_shamt [NUM_STAGES];
  logic                      w_sign  [NUM_STAGES];
  logic                      w_ready [NUM_STAGES+1];
  logic                      w_adv   [NUM_STAGES];

  // Ready chain is resolved from the output backwards so a full pipe can accept while draining.
  always_comb begin
    w_ready[NUM_STAGES] = out_ready;
    for (int unsigned j = 0; j < NUM_STAGES; j++) begin
      w_adv[NUM_STAGES-1-j]   = w_valid[NUM_STAGES-1-j] && w_ready[NUM_STAGES-j];
      w_ready[NUM_STAGES-1-j] = !w_valid[NUM_STAGES-1-j] || w_adv[NUM_STAGES-1-j];
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    logic                      w_load;
    logic [NUM_BITS-1:0]       w_src_data;
    logic [1:0]                w_src_op;
    logic [NUM_SHIFT_BITS-1:0] w_src_shamt;
    logic                      w_src_sign;
    logic [NUM_BITS-1:0]       w_nxt_data;

    logic                      r_valid;
    logic [NUM_BITS-1:0]       r_data;
    logic [1:0]                r_op;
    logic [NUM_SHIFT_BITS-1:0] r_shamt;
    logic                      r_sign;

    if (g == 0) begin : g_first
      assign w_load      = in_valid && w_ready[0];
      assign w_src_data  = in_data;
      assign w_src_op    = in_op;
      assign w_src_shamt = in_shamt;
      assign w_src_sign  = in_data[NUM_BITS-1];
    end else begin : g_next
      assign w_load      = w_adv[g-1];
      assign w_src_data  = w_data[g-1];
      assign w_src_op    = w_op[g-1];
      assign w_src_shamt = w_shamt[g-1];
      assign w_src_sign  = w_sign[g-1];
    end

    // Level k lives in stage floor(k*NUM_STAGES/NUM_SHIFT_BITS).
    always_comb begin
      w_nxt_data = w_src_data;
      for (int unsigned k = 0; k < NUM_SHIFT_BITS; k++) begin
        if (((k * NUM_STAGES) / NUM_SHIFT_BITS) == g && w_src_shamt[k]) begin
          w_nxt_data = f_level(w_src_op, w_nxt_data, w_src_sign, 32'd1 << k);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_op    <= '0;
        r_shamt <= '0;
        r_sign  <= 1'b0;
      end else if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_nxt_data;
        r_op    <= w_src_op;
        r_shamt <= w_src_shamt;
        r_sign  <= w_src_sign;
      end else if (w_adv[g]) begin
        r_valid <= 1'b0;
      end
    end

    assign w_valid[g] = r_valid;
    assign w_data[g]  = r_data;
    assign w_op[g]    = r_op;
    assign w_shamt[g] = r_shamt;
    assign w_sign[g]  = r_sign;
  end

  assign in_ready  = w_ready[0];
  assign out_valid = w_valid[NUM_STAGES-1];
  assign out_data  = w_data[NUM_STAGES-1];

endmodule

// File: tb/tb_dl_shift_pipe.sv
// Directed bench for dl_shift_pipe: ops, boundaries, streaming, backpressure,
// mid-flight reset, and a width/stage sweep on extra instances.
module tb_dl_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sw_rst_n = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dl_shift_pipe #(.NUM_BITS(32), .NUM_STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data(in_data), .in_shamt(in_shamt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference shift for width w (w <= 64), written directly from the operation definitions.
  function automatic logic [63:0] f_ref(input int unsigned w, input logic [1:0] op,
                                        input logic [63:0] din, input int unsigned s);
    logic [63:0] mask, d, dx;
    logic signed [63:0] sx;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    d = din & mask;
    case (op)
      2'd0: f_ref = (d << s) & mask;
      2'd1: f_ref = d >> s;
      2'd2: begin
        dx = d[w-1] ? (d | ~mask) : d;
        sx = $signed(dx) >>> s;
        f_ref = sx & mask;
      end
      default: f_ref = ((d << s) | (d >> (w - s))) & mask;
    endcase
  endfunction

  task automatic run_one(input string tag, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] s, input logic [31:0] exp);
    int lat;
    in_valid = 1'b1; in_op = op; in_data = d; in_shamt = s;
    #1 chk({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_data"}, out_data, exp);
    @(posedge clk); #1;
  endtask

  // Sweep instances: {8,32,64} x {1, max stages}, exhaustive op/shamt, random data.
  for (genvar gi = 0; gi < 6; gi++) begin : g_sweep
    localparam int unsigned SW = (gi / 2 == 0) ? 8 : (gi / 2 == 1) ? 32 : 64;
    localparam int unsigned SB = $clog2(SW);
    localparam int unsigned SS = (gi % 2 == 0) ? 1 : SB;
    logic          s_in_valid, s_in_ready, s_out_valid;
    logic [1:0]    s_op;
    logic [SW-1:0] s_data, s_out;
    logic [SB-1:0] s_shamt;
    logic          r_done = 1'b0;

    dl_shift_pipe #(.NUM_BITS(SW), .NUM_STAGES(SS)) u_sw (
      .clk(clk), .rst_n(sw_rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_op),
      .in_data(s_data), .in_shamt(s_shamt),
      .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out)
    );

    initial begin
      logic [63:0] rnd;
      int lat;
      s_in_valid = 1'b0; s_op = '0; s_data = '0; s_shamt = '0;
      while (!sw_rst_n) @(posedge clk);
      #1;
      for (int op = 0; op < 4; op++) begin
        for (int s = 0; s < SW; s++) begin
          rnd = {$urandom, $urandom};
          s_data = rnd[SW-1:0]; s_op = op[1:0]; s_shamt = s[SB-1:0];
          s_in_valid = 1'b1;
          @(posedge clk); #1;
          s_in_valid = 1'b0;
          lat = 1;
          while (!s_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
          end
          chk("sweep_lat", lat, SS);
          chk("sweep_data", s_out, f_ref(SW, op[1:0], rnd, s));
          @(posedge clk); #1;
        end
      end
      r_done = 1'b1;
    end
  end

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] d;
    logic [4:0]  s;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];
  logic [31:0] q [$];

  initial begin
    int t;
    vecs = '{
      '{2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000},
      '{2'd1, 32'h8000_0000, 5'd4,  32'h0800_0000},
      '{2'd2, 32'h8000_0000, 5'd4,  32'hF800_0000},
      '{2'd3, 32'h8000_0001, 5'd1,  32'h0000_0003},
      '{2'd0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF},
      '{2'd1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF},
      '{2'd2, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF},
      '{2'd3, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF},
      '{2'd2, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000},
      '{2'd3, 32'h1234_5678, 5'd16, 32'h5678_1234},
      '{2'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF},
      '{2'd1, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001},
      '{2'd3, 32'h8000_0000, 5'd31, 32'h4000_0000},
      '{2'd0, 32'hF0F0_F0F0, 5'd12, 32'h0F0F_0000}
    };
    in_valid = 1'b0; out_ready = 1'b1; in_op = '0; in_data = '0; in_shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1; sw_rst_n = 1'b1;

    for (int i = 0; i < 14; i++)
      run_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].d, vecs[i].s, vecs[i].exp);

    // Streaming: accept at edge e, result visible after edge e+1.
    for (int e = 0; e < 103; e++) begin
      if (e < 100) begin
        in_valid = 1'b1;
        in_op = 2'($urandom_range(0, 3));
        in_data = $urandom;
        in_shamt = 5'($urandom_range(0, 31));
        q.push_back(32'(f_ref(32, in_op, {32'd0, in_data}, in_shamt)));
        #1 chk("stream_rdy", in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("stream_vld", out_valid, (e >= 1 && e <= 100));
      if (out_valid) begin
        if (q.size() > 0) chk("stream_data", out_data, q.pop_front());
        else chk("stream_extra", out_valid, 0);
      end
    end
    chk("stream_left", q.size(), 0);

    // Backpressure: A=SLL 1<<4, B=SRA F0000000>>>8, C=ROL FF by 28.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_data = 32'h0000_0001; in_shamt = 5'd4;
    #1 chk("bp_rdy_a", in_ready, 1);
    @(posedge clk); #1;
    in_op = 2'd2; in_data = 32'hF000_0000; in_shamt = 5'd8;
    #1 chk("bp_rdy_b", in_ready, 1);
    @(posedge clk); #1;
    in_op = 2'd3; in_data = 32'h0000_00FF; in_shamt = 5'd28;
    #1 chk("bp_rdy_c_blocked", in_ready, 0);
    chk("bp_vld_a", out_valid, 1);
    chk("bp_data_a", out_data, 32'h0000_0010);
    @(posedge clk); #1;
    chk("bp_hold_a1", out_data, 32'h0000_0010);
    chk("bp_rdy_c_still", in_ready, 0);
    @(posedge clk); #1;
    chk("bp_hold_a2", out_data, 32'h0000_0010);
    out_ready = 1'b1;
    #1 chk("bp_rdy_c_drain", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_vld_b", out_valid, 1);
    chk("bp_data_b", out_data, 32'hFFF0_0000);
    @(posedge clk); #1;
    chk("bp_hold_b", out_data, 32'hFFF0_0000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_data_c", out_data, 32'hF000_000F);
    @(posedge clk); #1;
    chk("bp_empty", out_valid, 0);

    // Reset with two requests in flight and a third offered during reset.
    in_valid = 1'b1; in_op = 2'd0; in_data = 32'h0000_0003; in_shamt = 5'd1;
    @(posedge clk); #1;
    in_op = 2'd1; in_data = 32'hFFFF_0000; in_shamt = 5'd8;
    @(posedge clk); #1;
    chk("rmf_inflight", out_valid, 1);
    rst_n = 1'b0;
    in_op = 2'd3; in_data = 32'h1111_2222;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    chk("rmf_out_valid", out_valid, 0);
    chk("rmf_out_data", out_data, 0);
    chk("rmf_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rmf_no_stale", out_valid, 0);
    end

    t = 0;
    while (!(g_sweep[0].r_done && g_sweep[1].r_done && g_sweep[2].r_done &&
             g_sweep[3].r_done && g_sweep[4].r_done && g_sweep[5].r_done) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk("sweep_done", t < 20000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
